piece_write_ctr: RTL
====================

// Module: piece_write_ctr
// PURPOSE
//  Writer side of the board-memory interface. The collision controller reads board cells to decide
//  place/noplace; this block, started on "place", writes the active tetromino into board RAM.
//  It scans a 4x4 piece mask one cell per cycle and writes piece_id to each occupied, in-bounds cell.
//  It reports the number of cells written and whether any written cell is in row 0 (game-over input).
// PARAMETERS
//  BOARD_W  10  board width in cells
//  BOARD_H  20  board height in cells
//  X_W      4   width of pos_x
//  Y_W      5   width of pos_y
//  ID_W     3   width of piece id / board cell data
//  ADDR_W   8   board RAM address width (must cover BOARD_W*BOARD_H-1)
// PORTS
//  clk            in   1       clock, all state on posedge
//  Reset          in   1       asynchronous, active-high reset
//  Start          in   1       request write; accepted only when Ready=1
//  Ready          out  1       idle, able to accept Start
//  done           out  1       one-cycle pulse: write sequence complete
//  piece_mask     in   16      bit r*4+c set = cell (row r, col c) of the 4x4 box occupied
//  piece_id       in   ID_W    value written to each occupied cell (nonzero by convention)
//  pos_x          in   X_W     board column of box col 0
//  pos_y          in   Y_W     board row of box row 0 (row 0 = top)
//  wr_en          out  1       board RAM write strobe, single-cycle write, no ack
//  wr_addr        out  ADDR_W  (pos_y+r)*BOARD_W + (pos_x+c)
//  wr_data        out  ID_W    latched piece_id
//  cells_written  out  3       count of writes in the last sequence (0..4 for legal pieces; saturates at 7)
//  top_out        out  1       last sequence wrote a cell in board row 0
// BEHAVIOUR
//  - Reset (async): state=S_idle, idx=0, cells_written=0, top_out=0; outputs Ready=1, done=0, wr_en=0
//    the moment Reset rises. Reset mid-sequence aborts it; no done pulse; partial writes stand.
//  - States: S_idle -> S_scan on Start; S_scan -> S_scan while idx<15, S_done when idx==15;
//    S_done -> S_idle unconditionally.
//  - On Start accept (S_idle & Start): latch piece_mask, piece_id, pos_x, pos_y; idx<=0;
//    clear cells_written and top_out. Inputs may change freely afterwards.
//  - Start outside S_idle is ignored. Start held high re-triggers on the first S_idle cycle.
//  - S_scan: cell idx, r=idx[3:2], c=idx[1:0]. x=pos_x+c, y=pos_y+r computed 1 bit wider (no wrap).
//    wr_en = (ps==S_scan) & mask_q[idx] & (x<BOARD_W) & (y<BOARD_H), combinational from registered
//    state; wr_addr/wr_data valid in the same cycle. Out-of-bounds occupied cells are skipped silently.
//  - Each write: cells_written+=1 (saturating at 7); top_out<=1 if y==0. idx increments every S_scan cycle.
//  - Order: idx 0..15 ascending, exactly 16 S_scan cycles regardless of mask.
//  - Timing: Start sampled at edge 0 -> S_scan cycles 1..16 -> done=1 in cycle 17 -> Ready=1 in cycle 18.
//  - Ready = (ps==S_idle); done = (ps==S_done); cells_written/top_out are stable from done until the next
//    Start accept.
// TESTING
//  1. O piece: mask 16'h0033, id 2, (x4,y10) -> wr_en at addrs 104,105,114,115 data 2;
//     done in cycle 17; cells_written=4, top_out=0.
//  2. Right clip: mask 16'h000F, id 1, (x8,y0) -> writes addrs 8,9 only; cells_written=2, top_out=1.
//  3. Bottom clip: mask 16'h1111, (x0,y18) -> writes addrs 180,190 only; rows 20,21 skipped;
//     cells_written=2.
//  4. Start pulsed during S_scan -> ignored, single done. Start held high -> new sequence accepted
//     in cycle 18; cells_written cleared at the accept edge.
//  5. Reset raised at idx=5 -> wr_en=0 and Ready=1 immediately; no done; count=0.
//     A fresh Start then runs a full 16-cycle sequence.
//  6. mask 16'h0000 -> no wr_en for 16 cycles; done in cycle 17; cells_written=0, top_out=0.

Source files
------------

// File: rtl/piece_write_ctr_if.sv
// Board-memory writer bus: start/ready handshake, piece description in, RAM write strobe and
// sequence status out.
interface piece_write_ctr_if #(
  parameter int X_W    = 4,
  parameter int Y_W    = 5,
  parameter int ID_W   = 3,
  parameter int ADDR_W = 8
) ();
  logic              Start;
  logic              Ready;
  logic              done;
  logic [15:0]       piece_mask;
  logic [ID_W-1:0]   piece_id;
  logic [X_W-1:0]    pos_x;
  logic [Y_W-1:0]    pos_y;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [ID_W-1:0]   wr_data;
  logic [2:0]        cells_written;
  logic              top_out;

  modport master (
    output Start, piece_mask, piece_id, pos_x, pos_y,
    input  Ready, done, wr_en, wr_addr, wr_data, cells_written, top_out
  );

  modport slave (
    input  Start, piece_mask, piece_id, pos_x, pos_y,
    output Ready, done, wr_en, wr_addr, wr_data, cells_written, top_out
  );
endinterface

// File: rtl/piece_write_ctr.sv
// Writes the active tetromino into board RAM: scans the latched 4x4 mask one cell per cycle and
// writes piece_id to every occupied, in-bounds cell, tallying writes and row-0 hits.
//
// state  | meaning
// S_idle | waiting for Start; Ready high
// S_scan | visiting box cell idx (0..15), one per cycle
// S_done | one-cycle completion pulse
module piece_write_ctr #(
  parameter int BOARD_W = 10,
  parameter int BOARD_H = 20,
  parameter int X_W     = 4,
  parameter int Y_W     = 5,
  parameter int ID_W    = 3,
  parameter int ADDR_W  = 8
) (
  input logic               clk,
  input logic               Reset,
  piece_write_ctr_if.slave  bus
);

  typedef enum logic [1:0] {
    S_idle = 2'd0,
    S_scan = 2'd1,
    S_done = 2'd2
  } state_t;

  state_t            ps, ns;
  logic [3:0]        idx;
  logic [15:0]       mask_q;
  logic [ID_W-1:0]   id_q;
  logic [X_W-1:0]    px_q;
  logic [Y_W-1:0]    py_q;
  logic [2:0]        cnt_q;
  logic              top_q;

  logic              accept;
  logic [X_W:0]      cell_x;
  logic [Y_W:0]      cell_y;
  logic              in_bounds;
  logic              wr_en_c;
  logic [ADDR_W-1:0] row_base;

  // Coordinates carry one extra bit so a box hanging past the edge never wraps back in bounds.
  always_comb begin
    cell_x    = {1'b0, px_q} + {{(X_W-1){1'b0}}, idx[1:0]};
    cell_y    = {1'b0, py_q} + {{(Y_W-1){1'b0}}, idx[3:2]};
    in_bounds = (cell_x < (X_W+1)'(BOARD_W)) && (cell_y < (Y_W+1)'(BOARD_H));
    wr_en_c   = (ps == S_scan) && mask_q[idx] && in_bounds;
    row_base  = ADDR_W'(cell_y) * ADDR_W'(BOARD_W);
    accept    = (ps == S_idle) && bus.Start;
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) ps <= S_idle;
    else       ps <= ns;
  end

  always_comb begin
    ns = ps;
    case (ps)
      S_idle:  if (bus.Start) ns = S_scan;
      S_scan:  if (idx == 4'd15) ns = S_done;
      S_done:  ns = S_idle;
      default: ns = S_idle;
    endcase
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      idx    <= '0;
      mask_q <= '0;
      id_q   <= '0;
      px_q   <= '0;
      py_q   <= '0;
      cnt_q  <= '0;
      top_q  <= 1'b0;
    end else if (accept) begin
      idx    <= '0;
      mask_q <= bus.piece_mask;
      id_q   <= bus.piece_id;
      px_q   <= bus.pos_x;
      py_q   <= bus.pos_y;
      cnt_q  <= '0;
      top_q  <= 1'b0;
    end else if (ps == S_scan) begin
      idx <= idx + 4'd1;
      if (wr_en_c) begin
        if (cnt_q != 3'd7) cnt_q <= cnt_q + 3'd1;
        if (cell_y == '0) top_q <= 1'b1;
      end
    end
  end

  assign bus.Ready         = (ps == S_idle);
  assign bus.done          = (ps == S_done);
  assign bus.wr_en         = wr_en_c;
  assign bus.wr_addr       = row_base + ADDR_W'(cell_x);
  assign bus.wr_data       = id_q;
  assign bus.cells_written = cnt_q;
  assign bus.top_out       = top_q;

endmodule
